// File: rtl/display_scan_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | display_scan_ctrl_pkg                                                |
// | Shared constants for the seven-segment scan controller.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package display_scan_ctrl_pkg;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic       AN_OFF     = 1'b1;
  // Pin order on seg: DP,G,F,E,D,C,B,A (bit 7 down to 0)
  localparam int         SEG_DP_BIT = 7;
  localparam int         SEG_GA_MSB = 6;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_seven_segment.sv
// +----------------------------------------------------------------------+
// | seven_segment                                                        |
// | BCD to active-low segment decoder; non-BCD codes decode blank.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seven_segment
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg[6:0] = 7'h40;
      4'd1:    seg[6:0] = 7'h79;
      4'd2:    seg[6:0] = 7'h24;
      4'd3:    seg[6:0] = 7'h30;
      4'd4:    seg[6:0] = 7'h19;
      4'd5:    seg[6:0] = 7'h12;
      4'd6:    seg[6:0] = 7'h02;
      4'd7:    seg[6:0] = 7'h78;
      4'd8:    seg[6:0] = 7'h00;
      4'd9:    seg[6:0] = 7'h10;
      default: seg[6:0] = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | display_scan_ctrl                                                    |
// | Multiplexed 7-seg scanner with frame shadowing, blink and DP.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_CNT = SLOT_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  logic [1:0]              state_q, state_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
  logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic                    frame_start;
  logic [3:0]              cur_digit;
  logic [7:0]              dec_seg;

  assign frame_start = (state_q == ST_GUARD) && (slot_cnt_q == '0) && (idx_q == '0);
  assign cur_digit   = digits_sh_q[4*idx_q +: 4];

  seven_segment u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    digits_sh_d   = digits_sh_q;
    blink_sh_d    = blink_sh_q;
    dp_sh_d       = dp_sh_q;

    if (frame_start) begin
      digits_sh_d = digits_in;
      blink_sh_d  = blink_mask;
      dp_sh_d     = dp_mask;
      if (blink_cnt_q == BLK_LAST) begin
        blink_phase_d = ~blink_phase_q;
        blink_cnt_d   = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    // Disable overrides everything except the held blink phase.
    if (!en) begin
      state_d     = ST_OFF;
      slot_cnt_d  = '0;
      idx_d       = '0;
      blink_cnt_d = '0;
    end else if (state_q == ST_OFF) begin
      state_d    = ST_GUARD;
      slot_cnt_d = '0;
      idx_d      = '0;
    end else begin
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
      end
      state_d = (slot_cnt_d < GUARD_CNT) ? ST_GUARD : ST_DRIVE;
    end
  end

  always_comb begin
    an_d  = {NUM_DIGITS{AN_OFF}};
    seg_d = SEG_BLANK;
    if (state_q == ST_DRIVE) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!(blink_sh_q[idx_q] && blink_phase_q)) begin
        // Decoder's own DP bit is always off, so gating it keeps DP control here.
        seg_d = {dec_seg[SEG_DP_BIT] & ~dp_sh_q[idx_q], dec_seg[SEG_GA_MSB:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digits_sh_q   <= '0;
      blink_sh_q    <= '0;
      dp_sh_q       <= '0;
      an_q          <= {NUM_DIGITS{AN_OFF}};
      seg_q         <= SEG_BLANK;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_sh_q   <= digits_sh_d;
      blink_sh_q    <= blink_sh_d;
      dp_sh_q       <= dp_sh_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_start;

endmodule

`default_nettype wire
